// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: drains PS/2 scancodes, filters arrow keys
// into legal turns, buffers them and applies one per move_tick.
//
// Ports:
//   clk, rst            - clock, async active-low reset
//   kbd_data_ready      - receiver has a frame pending
//   kbd_scancode[7:0]   - frame scancode (8'h90..8'h93 are arrows)
//   kbd_released        - frame is a break code
//   kbd_err             - frame had a line/parity error
//   kbd_read            - one-cycle acknowledge to the receiver
//   move_tick           - one-cycle game step strobe
//   dir[1:0]            - heading: 0 right, 1 left, 2 up, 3 down
//   dir_changed         - pulse when dir is loaded from the buffer
//   paused              - game paused
//   fifo_count[3:0]     - buffered turns
//   drop_cnt[7:0]       - saturating error/overflow counter
module snake_dir_ctrl #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] CODE_PAUSE = 8'h29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbd_data_ready,
    input  logic [7:0] kbd_scancode,
    input  logic       kbd_released,
    input  logic       kbd_err,
    output logic       kbd_read,
    input  logic       move_tick,
    output logic [1:0] dir,
    output logic       dir_changed,
    output logic       paused,
    output logic [3:0] fifo_count,
    output logic [7:0] drop_cnt
);

    localparam int         PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] DEPTH = 4'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACK  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [7:0]    code_q, code_d;
    logic          rel_q, rel_d;
    logic          err_q, err_d;
    logic          kbd_read_q, kbd_read_d;
    logic [1:0]    dir_q, dir_d;
    logic          dir_changed_q, dir_changed_d;
    logic          paused_q, paused_d;
    logic [3:0]    count_q, count_d;
    logic [7:0]    drop_q, drop_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [1:0]    mem_d [FIFO_DEPTH];

    logic          in_ack;
    logic          frame_ok;
    logic          is_pause;
    logic          is_arrow;
    logic [1:0]    cand;
    logic [PW-1:0] tail_idx;
    logic [1:0]    ref_dir;
    logic          legal;
    logic          full;
    logic          pop;
    logic          push;
    logic          ovf;
    logic          flush;

    // Handshake FSM and frame capture
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        rel_d      = rel_q;
        err_d      = err_q;
        kbd_read_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (kbd_data_ready) begin
                    state_d    = S_ACK;
                    code_d     = kbd_scancode;
                    rel_d      = kbd_released;
                    err_d      = kbd_err;
                    kbd_read_d = 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!kbd_data_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame decode; only meaningful during the ACK cycle
    always_comb begin
        in_ack   = (state_q == S_ACK);
        frame_ok = in_ack && !err_q && !rel_q;
        is_pause = frame_ok && (code_q == CODE_PAUSE);
        is_arrow = frame_ok && !is_pause && !paused_q
                   && (code_q[7:2] == 6'b100100);
        cand     = code_q[1:0];
        tail_idx = wr_ptr_q - PW'(1);
        // Turns are checked against the last queued heading, not the
        // current one, so a burst of keys forms a legal path.
        ref_dir  = (count_q != 4'd0) ? mem_q[tail_idx] : dir_q;
        // Opposite headings differ only in bit 0 (0/1, 2/3).
        legal    = is_arrow && (cand != ref_dir)
                   && (cand != (ref_dir ^ 2'b01));
        full     = (count_q == DEPTH);
        pop      = move_tick && !paused_q && (count_q != 4'd0);
        push     = legal && (!full || pop);
        ovf      = legal && full && !pop;
        flush    = is_pause && !paused_q;
    end

    // Turn buffer, heading, pause and drop counter
    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        dir_d         = dir_q;
        dir_changed_d = pop;
        paused_d      = paused_q;
        drop_d        = drop_q;

        if (push) begin
            mem_d[wr_ptr_q] = cand;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            dir_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + 4'd1;
        end else if (pop && !push) begin
            count_d = count_q - 4'd1;
        end

        if (is_pause) begin
            paused_d = ~paused_q;
        end
        // Entering pause discards pending turns; a same-cycle pop still
        // lands in dir above.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 4'd0;
        end

        if (((in_ack && err_q) || ovf) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            code_q        <= 8'h00;
            rel_q         <= 1'b0;
            err_q         <= 1'b0;
            kbd_read_q    <= 1'b0;
            dir_q         <= 2'd0;
            dir_changed_q <= 1'b0;
            paused_q      <= 1'b0;
            count_q       <= 4'd0;
            drop_q        <= 8'h00;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 2'd0;
            end
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            rel_q         <= rel_d;
            err_q         <= err_d;
            kbd_read_q    <= kbd_read_d;
            dir_q         <= dir_d;
            dir_changed_q <= dir_changed_d;
            paused_q      <= paused_d;
            count_q       <= count_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_q         <= mem_d;
        end
    end

    assign kbd_read    = kbd_read_q;
    assign dir         = dir_q;
    assign dir_changed = dir_changed_q;
    assign paused      = paused_q;
    assign fifo_count  = count_q;
    assign drop_cnt    = drop_q;

endmodule
